// File: rtl/comb_bool_waveform2.sv
// Leaf decode cell: f = 1 for {a,b,c,d} in {3..11,15}, i.e. (a ^ b) | (c & d).
// Purely combinational; clk and reset are integration-only ports.
module comb_bool_waveform2 (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f
);

  logic [3:0] idx;
  logic       unused_ok;

  assign idx = {a, b, c, d};

  // clk/reset are deliberately left out of the function; folded here so they count as consumed.
  assign unused_ok = &{1'b0, clk, reset};

  always_comb begin
    f = 1'b0;
    case (idx)
      4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
      4'd8, 4'd9, 4'd10, 4'd11, 4'd15: f = 1'b1;
      default:                         f = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_comb_bool_waveform2.sv
// Directed bench for comb_bool_waveform2: truth-table sweep, corner vectors,
// and reset/clock independence sequences.
module tb_comb_bool_waveform2;

  logic clk;
  logic reset;
  logic a, b, c, d;
  logic f;

  int unsigned n_vec;
  int unsigned n_err;

  typedef struct {
    logic [3:0] abcd;
    logic       exp_f;
  } vec_t;

  vec_t vecs[$];

  comb_bool_waveform2 dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .f     (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: f=%b expected %b (abcd=%b%b%b%b reset=%b)",
               name, got, exp, a, b, c, d, reset);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  // Change inputs just after the rising edge, sample mid-cycle on the falling edge.
  task automatic apply(input logic [3:0] v, input logic exp, input string name);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check(name, f, exp);
  endtask

  initial begin
    logic [15:0] sweep_exp;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(4'b0000);

    // Reset asserted at power-up: f already follows inputs.
    @(negedge clk);
    check("por_0000", f, 1'b0);
    apply(4'b1111, 1'b1, "por_1111");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Expected f for index 15..0 (bit i = f at index i): 1000_1111_1111_1000.
    sweep_exp = 16'b1000_1111_1111_1000;
    for (int i = 0; i < 16; i++)
      vecs.push_back('{abcd: 4'(i), exp_f: sweep_exp[i]});
    // Corner points.
    vecs.push_back('{abcd: 4'b0000, exp_f: 1'b0});
    vecs.push_back('{abcd: 4'b1111, exp_f: 1'b1});
    vecs.push_back('{abcd: 4'b0011, exp_f: 1'b1});
    vecs.push_back('{abcd: 4'b1100, exp_f: 1'b0});
    // a=1,b=0: XOR term dominates regardless of c,d.
    vecs.push_back('{abcd: 4'b1000, exp_f: 1'b1});
    vecs.push_back('{abcd: 4'b1001, exp_f: 1'b1});
    vecs.push_back('{abcd: 4'b1010, exp_f: 1'b1});
    vecs.push_back('{abcd: 4'b1011, exp_f: 1'b1});
    // a=b=1: only the AND term can raise f.
    vecs.push_back('{abcd: 4'b1111, exp_f: 1'b1});
    vecs.push_back('{abcd: 4'b1110, exp_f: 1'b0});

    foreach (vecs[k])
      apply(vecs[k].abcd, vecs[k].exp_f, $sformatf("vec%0d_%b", k, vecs[k].abcd));

    // Reset independence mid-sweep.
    apply(4'b0101, 1'b1, "rst_pre_0101");
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_assert_0101", f, 1'b1);
    @(negedge clk);
    check("rst_high_0101", f, 1'b1);
    apply(4'b0000, 1'b0, "rst_high_0000");
    apply(4'b0101, 1'b1, "rst_high_back_0101");
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_deassert_0101", f, 1'b1);
    @(negedge clk);
    check("rst_low_0101", f, 1'b1);

    // Clock independence: hold 1001, sample on both sides of several edges.
    apply(4'b1001, 1'b1, "clk_hold_start");
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("clk_hold_pos%0d", e), f, 1'b1);
      @(negedge clk);
      check($sformatf("clk_hold_neg%0d", e), f, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
